// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle instruction controller: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB with memory wait states, a timeout fault, a global stall and a retire counter.
module multicycle_ctrl_fsm #(
    parameter int OPCODE_W = 6,
    parameter int CMD_W    = 4,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                stall,
    output logic                imem_r_en,
    output logic                ir_load,
    output logic [CMD_W-1:0]    exec_cmd,
    output logic                is_imm,
    output logic                single_src,
    output logic                if_store_bne,
    output logic [1:0]          branch_type,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic                wb_en,
    output logic                illegal_op,
    output logic                fault,
    output logic [CNT_W-1:0]    instr_count
);
    localparam int OW = (OPCODE_W > 6) ? OPCODE_W : 6;
    localparam logic [WAIT_W-1:0] WMAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    typedef struct packed {
        logic       legal;
        logic       nop;
        logic       ld;
        logic       st;
        logic       br;
        logic       imm;
        logic       ss;
        logic       isb;
        logic [1:0] btype;
        logic [3:0] cmd;
    } dec_t;

    function automatic dec_t decode(input logic [OPCODE_W-1:0] op);
        dec_t d;
        d = '0;
        d.legal = 1'b1;
        case (OW'(op))
            OW'(6'h00): d.nop = 1'b1;
            OW'(6'h01): d.cmd = 4'b0000;
            OW'(6'h03): d.cmd = 4'b0010;
            OW'(6'h05): d.cmd = 4'b0100;
            OW'(6'h06): d.cmd = 4'b0101;
            OW'(6'h07): d.cmd = 4'b0110;
            OW'(6'h08): d.cmd = 4'b0111;
            OW'(6'h09): d.cmd = 4'b1000;
            OW'(6'h0A): d.cmd = 4'b1000;
            OW'(6'h0B): d.cmd = 4'b1001;
            OW'(6'h0C): d.cmd = 4'b1010;
            OW'(6'h20): begin d.imm = 1'b1; d.ss = 1'b1; end
            OW'(6'h21): begin d.imm = 1'b1; d.ss = 1'b1; d.cmd = 4'b0010; end
            OW'(6'h24): begin d.imm = 1'b1; d.ss = 1'b1; d.ld = 1'b1; end
            OW'(6'h25): begin d.imm = 1'b1; d.isb = 1'b1; d.st = 1'b1; end
            OW'(6'h28): begin d.imm = 1'b1; d.ss = 1'b1; d.br = 1'b1; d.btype = 2'b01; end
            OW'(6'h29): begin d.imm = 1'b1; d.isb = 1'b1; d.br = 1'b1; d.btype = 2'b10; end
            OW'(6'h2A): begin d.imm = 1'b1; d.ss = 1'b1; d.br = 1'b1; d.btype = 2'b11; end
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ill_q, ill_d, fault_q, fault_d;
    dec_t                dq, dn;
    logic                unused_dec;

    assign dq = decode(op_q);
    assign dn = decode(opcode);
    assign unused_dec = ^{dq, dn};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            wait_q  <= '0;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            fault_q <= 1'b0;
        end else if (!stall) begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            fault_q <= fault_d;
        end
    end

    // wait_d defaults to zero so every transition clears the counter; only waiting states count up
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = '0;
        cnt_d        = cnt_q;
        ill_d        = ill_q;
        fault_d      = fault_q;
        imem_r_en    = 1'b0;
        ir_load      = 1'b0;
        exec_cmd     = '0;
        is_imm       = 1'b0;
        single_src   = 1'b0;
        if_store_bne = 1'b0;
        branch_type  = 2'b00;
        mem_r_en     = 1'b0;
        mem_w_en     = 1'b0;
        wb_en        = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_r_en = 1'b1;
                if (imem_ready) begin
                    ir_load = !stall;
                    state_d = S_DECODE;
                end else if (wait_q == WMAX) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (!dn.legal) begin
                    ill_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (dn.nop) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                exec_cmd     = CMD_W'(dq.cmd);
                is_imm       = dq.imm;
                single_src   = dq.ss;
                if_store_bne = dq.isb;
                branch_type  = dq.btype;
                if (dq.br) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = (dq.ld || dq.st) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                exec_cmd     = CMD_W'(dq.cmd);
                is_imm       = dq.imm;
                single_src   = dq.ss;
                if_store_bne = dq.isb;
                mem_r_en     = dq.ld;
                mem_w_en     = dq.st;
                if (dmem_ready) begin
                    if (dq.ld) begin
                        state_d = S_WB;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WMAX) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                wb_en   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // a reset cycle must never leak a strobe from the aborted instruction
        if (!rst_n) begin
            imem_r_en    = 1'b0;
            ir_load      = 1'b0;
            exec_cmd     = '0;
            is_imm       = 1'b0;
            single_src   = 1'b0;
            if_store_bne = 1'b0;
            branch_type  = 2'b00;
            mem_r_en     = 1'b0;
            mem_w_en     = 1'b0;
            wb_en        = 1'b0;
        end
    end

    assign illegal_op  = ill_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a phase-queue reference model.
module tb_multicycle_ctrl_fsm;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;
    localparam byte PD = 8'h44, PE = 8'h45, PM = 8'h4D, PW = 8'h57;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic             imem_ready = 1'b0, dmem_ready = 1'b0, stall = 1'b0;
    logic             imem_r_en, ir_load, is_imm, single_src, if_store_bne;
    logic [3:0]       exec_cmd;
    logic [1:0]       branch_type;
    logic             mem_r_en, mem_w_en, wb_en, illegal_op, fault;
    logic [CNT_W-1:0] instr_count;

    multicycle_ctrl_fsm #(.OPCODE_W(6), .CMD_W(4), .WAIT_W(4), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .stall(stall), .imem_r_en(imem_r_en), .ir_load(ir_load), .exec_cmd(exec_cmd), .is_imm(is_imm),
        .single_src(single_src), .if_store_bne(if_store_bne), .branch_type(branch_type),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .illegal_op(illegal_op),
        .fault(fault), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit       legal, nop, ld, st, br, imm, ss, isb;
        bit [1:0] bt;
        bit [3:0] cmd;
    } attr_t;

    // Opcode table as written in the instruction set description
    function automatic attr_t spec_attr(input bit [5:0] op);
        attr_t a;
        a = '0;
        a.legal = 1'b1;
        case (op)
            6'h00: a.nop = 1'b1;
            6'h01: a.cmd = 4'h0;
            6'h03: a.cmd = 4'h2;
            6'h05: a.cmd = 4'h4;
            6'h06: a.cmd = 4'h5;
            6'h07: a.cmd = 4'h6;
            6'h08: a.cmd = 4'h7;
            6'h09, 6'h0A: a.cmd = 4'h8;
            6'h0B: a.cmd = 4'h9;
            6'h0C: a.cmd = 4'hA;
            6'h20: begin a.imm = 1; a.ss = 1; end
            6'h21: begin a.imm = 1; a.ss = 1; a.cmd = 4'h2; end
            6'h24: begin a.imm = 1; a.ss = 1; a.ld = 1; end
            6'h25: begin a.imm = 1; a.st = 1; a.isb = 1; end
            6'h28: begin a.imm = 1; a.ss = 1; a.br = 1; a.bt = 2'b01; end
            6'h29: begin a.imm = 1; a.isb = 1; a.br = 1; a.bt = 2'b10; end
            6'h2A: begin a.imm = 1; a.ss = 1; a.br = 1; a.bt = 2'b11; end
            default: a.legal = 1'b0;
        endcase
        return a;
    endfunction

    // Reference: an empty plan means fetching; otherwise plan holds the phases still to run
    byte  plan[$];
    bit   halted = 0, m_ill = 0, m_fault = 0, m_init = 0;
    int   waits = 0, m_cnt = 0;
    bit [5:0] m_op = '0;

    always @(negedge clk) begin : model
        attr_t a, n;
        logic [13:0] exp_s, act_s;
        a = spec_attr(m_op);
        exp_s = '0;
        if (m_init) begin
            if (rst_n && !halted) begin
                if (plan.size() == 0) begin
                    exp_s[13] = 1'b1;
                    exp_s[12] = imem_ready && !stall;
                end else if (plan[0] == PE) exp_s[11:0] = {a.cmd, a.imm, a.ss, a.isb, a.bt, 3'b000};
                else if (plan[0] == PM) exp_s[11:0] = {a.cmd, a.imm, a.ss, a.isb, 2'b00, a.ld, a.st, 1'b0};
                else if (plan[0] == PW) exp_s[0] = 1'b1;
            end
            act_s = {imem_r_en, ir_load, exec_cmd, is_imm, single_src, if_store_bne, branch_type,
                     mem_r_en, mem_w_en, wb_en};
            chk("strobes", 32'(act_s), 32'(exp_s));
            chk("instr_count", 32'(instr_count), 32'(m_cnt));
            chk("sticky", 32'({illegal_op, fault}), 32'({m_ill, m_fault}));
        end
        if (!rst_n) begin
            plan.delete(); halted = 0; m_ill = 0; m_fault = 0; waits = 0; m_op = '0; m_cnt = 0; m_init = 1;
        end else if (m_init && !stall && !halted) begin
            if (plan.size() == 0) begin
                if (imem_ready) begin plan.push_back(PD); waits = 0; end
                else if (waits == MAX_WAIT) begin halted = 1; m_fault = 1; end
                else waits++;
            end else if (plan[0] == PD) begin
                n = spec_attr(opcode);
                m_op = opcode;
                void'(plan.pop_front());
                waits = 0;
                if (!n.legal) m_ill = 1;
                else if (n.nop) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                else begin
                    plan.push_back(PE);
                    if (n.ld || n.st) plan.push_back(PM);
                    if (!n.br && !n.st) plan.push_back(PW);
                end
            end else if (plan[0] == PM && !dmem_ready) begin
                if (waits == MAX_WAIT) begin halted = 1; m_fault = 1; end
                else waits++;
            end else begin
                void'(plan.pop_front());
                waits = 0;
                if (plan.size() == 0) m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    bit [5:0] legal_ops[18] = '{6'h00, 6'h01, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
                                6'h0B, 6'h0C, 6'h20, 6'h21, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2A};
    int pr_i[4] = '{70, 30, 5, 95};
    int pr_d[4] = '{60, 30, 50, 95};

    initial begin
        int nmem;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD with both memories always ready
        imem_ready = 1; dmem_ready = 1; opcode = 6'h01;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("reset_count", 32'(instr_count), 32'd0);
                chk("reset_sticky", 32'({illegal_op, fault}), 32'd0);
                chk("add_irload_c1", 32'(ir_load), 32'd1);
            end
            if (k == 3) chk("add_cmd_c3", 32'({exec_cmd, single_src}), 32'd0);
            if (k == 4) chk("add_wb_c4", 32'(wb_en), 32'd1);
            if (k == 5) chk("add_count_c5", 32'(instr_count), 32'd1);
            next_cycle();
        end

        // LD with data memory three wait states late
        opcode = 6'h24; nmem = 0;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            dmem_ready = (k >= 7);
            @(negedge clk);
            if (mem_r_en) begin nmem++; chk("ld_imm", 32'(is_imm), 32'd1); end
            if (k == 8) chk("ld_wb_c8", 32'(wb_en), 32'd1);
            next_cycle();
        end
        chk("ld_mem_cycles", 32'(nmem), 32'd4);
        chk("ld_fault", 32'(fault), 32'd0);

        // BNE followed by an illegal opcode
        opcode = 6'h29; dmem_ready = 1;
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) opcode = 6'h3F;
            @(negedge clk);
            if (k == 3) chk("bne_sel", 32'({branch_type, if_store_bne}), 32'b101);
            if (k == 5) chk("ill_before", 32'(illegal_op), 32'd0);
            if (k == 6) chk("ill_after", 32'({illegal_op, instr_count}), 32'h11);
            next_cycle();
        end

        // Instruction fetch never ready: timeout into HALT
        imem_ready = 0; opcode = 6'h00;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            if (k >= 18) imem_ready = 1;
            @(negedge clk);
            if (k == 16) chk("to_c16", 32'({fault, imem_r_en}), 32'b01);
            if (k == 17) chk("to_c17", 32'({fault, imem_r_en}), 32'b10);
            if (k == 20) chk("halt_hold", 32'({imem_r_en, ir_load, fault}), 32'b001);
            next_cycle();
        end

        // Ready arriving on the last tolerated wait cycle wins over the timeout
        imem_ready = 0;
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            imem_ready = (k == 16);
            @(negedge clk);
            if (k == 16) chk("rdy_wins_load", 32'(ir_load), 32'd1);
            if (k == 17) chk("rdy_wins_fault", 32'(fault), 32'd0);
            next_cycle();
        end

        // Stall held three cycles across a store's memory phase
        opcode = 6'h25; imem_ready = 1; dmem_ready = 1;
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            stall = (k >= 4 && k <= 6);
            @(negedge clk);
            if (k >= 4 && k <= 7) chk("st_stall_wen", 32'(mem_w_en), 32'd1);
            if (k == 6) chk("st_stall_cnt", 32'(instr_count), 32'd0);
            if (k == 8) chk("st_exit", 32'({mem_w_en, instr_count}), 32'h01);
            next_cycle();
        end
        stall = 0;

        // 17 NOPs wrap the 4-bit counter to 1, then reset lands mid-LD
        opcode = 6'h00; dmem_ready = 0;
        do_reset();
        for (int k = 1; k <= 41; k++) begin
            if (k == 35) opcode = 6'h24;
            if (k == 40) rst_n = 0;
            if (k == 41) rst_n = 1;
            @(negedge clk);
            if (k == 35) chk("nop_wrap", 32'(instr_count), 32'd1);
            if (k == 39) chk("midld_ren", 32'(mem_r_en), 32'd1);
            if (k == 40) chk("midld_rst_ren", 32'(mem_r_en), 32'd0);
            if (k == 41) chk("midld_after", 32'({instr_count, imem_r_en}), 32'd1);
            next_cycle();
        end

        // Randomized traffic under several memory responsiveness profiles
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 800; n++) begin
                imem_ready = ($urandom_range(99) < pr_i[seg]);
                dmem_ready = ($urandom_range(99) < pr_d[seg]);
                stall      = ($urandom_range(99) < 12);
                opcode     = ($urandom_range(3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(17)];
                rst_n      = ($urandom_range(seg == 2 ? 60 : 400) != 0);
                next_cycle();
            end
        end
        rst_n = 1; stall = 0;
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
